// File: rtl/pipo_rr_loader_if.sv
// rtl/pipo_rr_loader_if.sv - requester/sink bundle for the round-robin PIPO loader
interface pipo_rr_loader_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  // Environment side: drives requests and sink readiness
  modport master (
    output req, req_data, out_ready,
    input  gnt, out_data, out_id, out_valid, busy
  );

  // Loader side
  modport slave (
    input  req, req_data, out_ready,
    output gnt, out_data, out_id, out_valid, busy
  );
endinterface

// File: rtl/pipo_rr_loader.sv
// rtl/pipo_rr_loader.sv - round-robin arbitrated loader for a shared PIPO holding register
module pipo_rr_loader #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  pipo_rr_loader_if.slave  bus
);

  // Holding-register state is just the valid flag
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             full;
  logic             cap;
  logic             found;
  logic [IDW-1:0]   sel;
  logic [IDW:0]     sum;
  logic [WIDTH-1:0] sel_data;

  assign full = (state_q == ST_FULL);

  // A new word may enter when the register is empty or being drained this cycle
  assign cap = (|bus.req) && (!full || bus.out_ready);

  // Rotating-priority search starting at ptr; sum wraps modulo NREQ without a divider
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      if (!found && bus.req[sum[IDW-1:0]]) begin
        found = 1'b1;
        sel   = sum[IDW-1:0];
      end
    end
  end

  assign sel_data = bus.req_data[sel*WIDTH +: WIDTH];

  // Grant is suppressed during reset so nothing upstream sees a phantom capture
  always_comb begin
    bus.gnt = '0;
    if (cap && rst_n) begin
      bus.gnt = {{(NREQ-1){1'b0}}, 1'b1} << sel;
    end
  end

  // Next state: capture wins over drain so back-to-back transfers never bubble
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    ptr_d      = ptr_q;
    if (cap) begin
      state_d    = ST_FULL;
      out_data_d = sel_data;
      out_id_d   = sel;
      ptr_d      = (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
    end else if (full && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State registers; asynchronous reset discards any held word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_valid = full;
  assign bus.busy      = full;

endmodule

// File: tb/tb_pipo_rr_loader.sv
// tb/tb_pipo_rr_loader.sv - directed self-checking bench for pipo_rr_loader
module tb_pipo_rr_loader;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipo_rr_loader_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  pipo_rr_loader #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0);
    bus.req_data = {d3, d2, d1, d0};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    set_data(4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    bus.req = 4'b1111;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_id !== 2'd0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs got v=%b d=%h id=%0d busy=%b exp v=0 d=0 id=0 busy=0",
               bus.out_valid, bus.out_data, bus.out_id, bus.busy);
    end
    total++;
    if (bus.gnt !== 4'b0000) begin
      bad++;
      $display("FAIL reset_gnt got=%b exp=0000", bus.gnt);
    end
    bus.req = 4'b0000;
    tick();
    rst_n = 1'b1;
    // Load 0xA from requester 0, which moves ptr to 1
    bus.req = 4'b0001;
    set_data(4'h0, 4'h0, 4'h0, 4'hA);
    tick();
    bus.req = 4'b0000;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA) begin
      bad++;
      $display("FAIL reset_preload got v=%b d=%h exp v=1 d=a", bus.out_valid, bus.out_data);
    end
    // Asynchronous reset mid-transfer, checked before any clock edge
    bus.req = 4'b0011;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_id !== 2'd0 || bus.gnt !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async got v=%b d=%h id=%0d gnt=%b exp v=0 d=0 id=0 gnt=0000",
               bus.out_valid, bus.out_data, bus.out_id, bus.gnt);
    end
    tick();
    // Release with requests present: ptr must be back at 0
    set_data(4'h0, 4'h0, 4'h6, 4'h3);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL reset_release_gnt got=%b exp=0001", bus.gnt);
    end
    tick();
    bus.req = 4'b0000;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== 4'h3) begin
      bad++;
      $display("FAIL reset_release_load got v=%b id=%0d d=%h exp v=1 id=0 d=3",
               bus.out_valid, bus.out_id, bus.out_data);
    end
  endtask

  task automatic test_single;
    bus.req = 4'b0100;
    set_data(4'h0, 4'h5, 4'h0, 4'h0);
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.gnt !== 4'b0100) begin
      bad++;
      $display("FAIL single_gnt got=%b exp=0100", bus.gnt);
    end
    tick();
    bus.req = 4'b0000;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd2 || bus.out_data !== 4'h5) begin
      bad++;
      $display("FAIL single_out got v=%b id=%0d d=%h exp v=1 id=2 d=5",
               bus.out_valid, bus.out_id, bus.out_data);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_id [5];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.req = 4'b1111;
    set_data(4'h4, 4'h3, 4'h2, 4'h1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (bus.gnt !== (4'b0001 << exp_id[i])) begin
        bad++;
        $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, bus.gnt, 4'b0001 << exp_id[i]);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id[i] || bus.out_data !== 4'(exp_id[i]) + 4'h1) begin
        bad++;
        $display("FAIL rr_out[%0d] got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                 i, bus.out_valid, bus.out_id, bus.out_data, exp_id[i], 4'(exp_id[i]) + 4'h1);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_backpressure;
    // ptr is 1 here; only requester 0 asks
    bus.req = 4'b0001;
    set_data(4'h0, 4'h0, 4'h7, 4'h9);
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_data !== 4'h9 || bus.out_id !== 2'd0) begin
      bad++;
      $display("FAIL bp_load got d=%h id=%0d exp d=9 id=0", bus.out_data, bus.out_id);
    end
    bus.req = 4'b0010;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (bus.gnt !== 4'b0000) begin
        bad++;
        $display("FAIL bp_gnt[%0d] got=%b exp=0000", i, bus.gnt);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h9 || bus.out_id !== 2'd0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d exp v=1 d=9 id=0",
                 i, bus.out_valid, bus.out_data, bus.out_id);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.gnt !== 4'b0010) begin
      bad++;
      $display("FAIL bp_release_gnt got=%b exp=0010", bus.gnt);
    end
    tick();
    bus.req = 4'b0000;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h7 || bus.out_id !== 2'd1) begin
      bad++;
      $display("FAIL bp_release_out got v=%b d=%h id=%0d exp v=1 d=7 id=1",
               bus.out_valid, bus.out_data, bus.out_id);
    end
  endtask

  task automatic test_drain;
    bus.req = 4'b0000;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.gnt !== 4'b0000) begin
      bad++;
      $display("FAIL drain_gnt got=%b exp=0000", bus.gnt);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 4'h7 || bus.out_id !== 2'd1) begin
      bad++;
      $display("FAIL drain_out got v=%b busy=%b d=%h id=%0d exp v=0 busy=0 d=7 id=1",
               bus.out_valid, bus.busy, bus.out_data, bus.out_id);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h7) begin
      bad++;
      $display("FAIL drain_idle got v=%b d=%h exp v=0 d=7", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_wrap;
    // ptr is 2; granting requester 2 moves it to 3
    bus.req = 4'b0100;
    set_data(4'hD, 4'hC, 4'hB, 4'hE);
    bus.out_ready = 1'b1;
    tick();
    bus.req = 4'b1001;
    #1;
    total++;
    if (bus.gnt !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_gnt3 got=%b exp=1000", bus.gnt);
    end
    tick();
    total++;
    if (bus.out_id !== 2'd3 || bus.out_data !== 4'hD) begin
      bad++;
      $display("FAIL wrap_out3 got id=%0d d=%h exp id=3 d=d", bus.out_id, bus.out_data);
    end
    bus.req = 4'b0001;
    #1;
    total++;
    if (bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_gnt0 got=%b exp=0001", bus.gnt);
    end
    tick();
    total++;
    if (bus.out_id !== 2'd0 || bus.out_data !== 4'hE) begin
      bad++;
      $display("FAIL wrap_out0 got id=%0d d=%h exp id=0 d=e", bus.out_id, bus.out_data);
    end
    // ptr should now be 1
    bus.req = 4'b1111;
    #1;
    total++;
    if (bus.gnt !== 4'b0010) begin
      bad++;
      $display("FAIL wrap_ptr1 got=%b exp=0010", bus.gnt);
    end
    tick();
    bus.req = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipo_rr_loader.md
Name: pipo_rr_loader

Overview:
- Shares one WIDTH-bit parallel-in/parallel-out holding register between NREQ requesters using round-robin arbitration.
- The winning requester's word is loaded into the register and presented downstream with a valid/ready handshake.
- Sits in front of the PIPO stage wherever several producers feed one parallel sink.
- Sustains one transfer per clock when the sink is always ready.

Parameters:
- WIDTH, 4, data word width in bits
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), width of requester index

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester request; acts as valid, held until granted
- req_data  input  NREQ*WIDTH  requester i's word in bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot combinational grant; high in the cycle that requester's word is captured
- out_data  output  WIDTH  registered held word
- out_id  output  IDW  index of the requester that supplied out_data
- out_valid  output  1  out_data/out_id valid
- out_ready  input  1  sink accepts the word this cycle
- busy  output  1  equals out_valid

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, any time, including mid-transfer), applied asynchronously:
  - out_data=0, out_id=0, out_valid=0, round-robin pointer ptr=0.
  - gnt is forced to all-zero while rst_n is low.
  - Any word held at reset is discarded.
- FSM, two states encoded by out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Capture condition: cap = |req && (!out_valid || out_ready).
- Arbitration (combinational):
  - sel = first index i with req[i]=1, searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - gnt = cap ? (1<<sel) : 0.
  - gnt is never multi-hot, and never asserted while FULL and out_ready=0.
- At each rising edge:
  - If cap: out_data<=req_data[sel], out_id<=sel, out_valid<=1, ptr<=(sel+1) mod NREQ.
  - Else if out_valid && out_ready: out_valid<=0; out_data and out_id hold their last values.
  - Else: all registers hold.
- Transitions:
  - EMPTY→FULL on cap.
  - FULL→FULL on out_ready with cap (back-to-back; new word replaces old in the same edge).
  - FULL→EMPTY on out_ready without cap.
  - FULL holds while out_ready=0.
- Latency: word is visible on out_data one cycle after its gnt cycle. Throughput is 1 word/cycle.
- Stability: while out_valid=1 and out_ready=0, out_data and out_id must not change.
- Requester rule:
  - req[i] and its data stay stable until sampled with gnt[i]=1.
  - A requester may keep req high to queue another word; the pointer has already moved past it.
- Fairness: a continuously requesting requester is granted within NREQ captures.
- Wrap-around: when sel=NREQ-1, ptr becomes 0.
- Simultaneous events:
  - Sink handshake and new capture in the same cycle are both honoured.
  - A request arriving in the same cycle as a reset release is evaluated on the first edge after reset release.
- out_ready while EMPTY has no effect.

Test Plan:
- Reset: drive rst_n low mid-transfer (out_valid=1, out_data=0xA) → out_valid=0, out_data=0, out_id=0, gnt=0 immediately, without waiting for a clock edge; after release with req=0001, gnt=0001 and ptr starts at 0.
- Single requester: req=0100, req_data[2]=0x5, out_ready=1 → gnt=0100 same cycle; next cycle out_data=0x5, out_id=2, out_valid=1.
- Round robin: all req=1111 held, data i=0x1..0x4, out_ready=1 → grant order 0,1,2,3,0; out_id sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
- Backpressure:
  - Load 0x9, then hold out_ready=0 for 5 cycles with req=0010 → gnt=0 and out_data=0x9 stable for all 5 cycles.
  - Raise out_ready → gnt=0010 that cycle, next out_data=requester 1's word.
- Drain: one word held, out_ready=1, req=0 → next cycle out_valid=0, out_data retains its value, busy=0.
- Wrap/fairness: NREQ=4, ptr=3, req=1001 → gnt=1000 then 0001; ptr returns to 1.
